// File: rtl/eth_fcs_pkg.sv
// Shared constants, FSM state type and small byte-lane helpers for the
// Ethernet FCS/pad insertion stage.
package eth_fcs_pkg;

    localparam logic [31:0] CRC32_POLY_REFL         = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT              = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE           = 32'hDEBB20E3;
    localparam int          MIN_FRAME_BYTES_DEFAULT = 60;

    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_PAD  = 2'd1,
        ST_FCS  = 2'd2
    } state_t;

    // Number of valid bytes in a contiguous-from-bit-0 tkeep.
    function automatic logic [3:0] keep_count(input logic [7:0] keep);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, keep[i]};
        return c;
    endfunction

    // tkeep with the lowest cnt bits set.
    function automatic logic [7:0] count_keep(input logic [3:0] cnt);
        logic [7:0] k;
        k = '0;
        for (int i = 0; i < 8; i++) if (4'(i) < cnt) k[i] = 1'b1;
        return k;
    endfunction

    // Byte mask covering the lowest cnt byte lanes of a 64-bit word.
    function automatic logic [63:0] count_mask(input logic [3:0] cnt);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) if (4'(i) < cnt) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

endpackage

// File: rtl/eth_crc32_d64.sv
// Combinational CRC-32 (reflected) update over the lowest byte_count bytes
// of a 64-bit word, byte 0 first. byte_count of 0 leaves the CRC unchanged.
module eth_crc32_d64
    import eth_fcs_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [63:0] data,
    input  logic [3:0]  byte_count,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // Bitwise LSB-first CRC over each enabled byte lane in order.
    always_comb begin
        c = crc_in;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < byte_count) begin
                c = c ^ {24'h000000, data[8*b +: 8]};
                for (int k = 0; k < 8; k++) begin
                    c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
                end
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_fcs_pad_insert.sv
// Ethernet TX framing: zero-pads runts to the minimum length, appends the
// CRC-32 FCS right after the last data byte, and drives one registered
// AXI4-Stream output stage.
// Handshake: a beat moves on any rising edge where tvalid && tready; the
// output holds tdata/tkeep/tlast/tuser while tvalid && !tready and never
// drops tvalid without a handshake (except on reset).
module eth_fcs_pad_insert
    import eth_fcs_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int KEEP_WIDTH      = 8,
    parameter int MIN_FRAME_BYTES = MIN_FRAME_BYTES_DEFAULT,
    parameter int PAD_ENABLE      = 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [31:0]           frame_count,
    output logic [1:0]            fsm_state
);

    localparam logic [6:0] MIN_B = 7'(MIN_FRAME_BYTES);

    state_t      state, state_nxt;
    logic [31:0] crc, crc_nxt;
    logic [6:0]  byte_cnt, cnt_nxt;
    logic        tuser_acc, tuser_nxt;
    logic [31:0] fcs_rem, fcs_rem_nxt;
    logic [7:0]  rem_keep, rem_keep_nxt;
    logic        ready_q;

    logic        out_ready, accept, load;
    logic [3:0]  beat_bytes;
    logic [6:0]  total, pad_left;
    logic [63:0] masked;
    logic        frame_user, pad_now;
    logic        fin;
    logic [63:0] fin_data;
    logic [3:0]  fin_m;
    logic [63:0] crc_data;
    logic [3:0]  crc_bytes;
    logic [31:0] crc_calc, fcs;
    logic [63:0] tdata_nxt;
    logic [7:0]  tkeep_nxt;
    logic        tlast_nxt, tuser_o_nxt;

    assign out_ready     = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = ready_q && (state == ST_PASS) && out_ready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign fcs           = ~crc_calc;
    assign fsm_state     = state;

    eth_crc32_d64 u_crc (
        .crc_in     (crc),
        .data       (crc_data),
        .byte_count (crc_bytes),
        .crc_out    (crc_calc)
    );

    // Datapath select: decide whether this cycle closes the frame (data + FCS)
    // and which bytes feed the CRC.
    always_comb begin
        pad_left   = MIN_B - byte_cnt;
        beat_bytes = s_axis_tlast ? keep_count(s_axis_tkeep) : 4'd8;
        total      = byte_cnt + {3'b000, beat_bytes};
        masked     = s_axis_tdata & count_mask(beat_bytes);
        frame_user = tuser_acc | ((state == ST_PASS) && s_axis_tuser);
        pad_now    = (PAD_ENABLE != 0) && (total < MIN_B);
        fin        = 1'b0;
        fin_data   = '0;
        fin_m      = '0;
        crc_data   = '0;
        crc_bytes  = '0;
        case (state)
            ST_PASS: begin
                if (accept) begin
                    if (s_axis_tlast && pad_now && (pad_left <= 7'd8)) begin
                        // Pad ends inside this beat: data, zeros up to the minimum, then FCS.
                        fin      = 1'b1;
                        fin_data = masked;
                        fin_m    = pad_left[3:0];
                    end else if (s_axis_tlast && !pad_now) begin
                        fin      = 1'b1;
                        fin_data = masked;
                        fin_m    = beat_bytes;
                    end else begin
                        // Full beat, or a runt's last beat zero-filled to 8 bytes.
                        crc_data  = masked;
                        crc_bytes = 4'd8;
                    end
                end
            end
            ST_PAD: begin
                if (out_ready) begin
                    if (pad_left <= 7'd8) begin
                        fin   = 1'b1;
                        fin_m = pad_left[3:0];
                    end else begin
                        crc_bytes = 4'd8;
                    end
                end
            end
            default: ;
        endcase
        if (fin) begin
            crc_data  = fin_data;
            crc_bytes = fin_m;
        end
    end

    // Next-state and output-register contents.
    always_comb begin
        state_nxt    = state;
        crc_nxt      = crc;
        cnt_nxt      = byte_cnt;
        tuser_nxt    = tuser_acc;
        fcs_rem_nxt  = fcs_rem;
        rem_keep_nxt = rem_keep;
        load         = 1'b0;
        tdata_nxt    = m_axis_tdata;
        tkeep_nxt    = m_axis_tkeep;
        tlast_nxt    = m_axis_tlast;
        tuser_o_nxt  = m_axis_tuser;
        case (state)
            ST_PASS: begin
                if (accept && !fin) begin
                    load        = 1'b1;
                    crc_nxt     = crc_calc;
                    cnt_nxt     = s_axis_tlast ? (byte_cnt + 7'd8)
                                               : ((total > 7'd64) ? 7'd64 : total);
                    tuser_nxt   = frame_user;
                    tdata_nxt   = masked;
                    tkeep_nxt   = 8'hFF;
                    tlast_nxt   = 1'b0;
                    tuser_o_nxt = 1'b0;
                    if (s_axis_tlast) state_nxt = ST_PAD;
                end
            end
            ST_PAD: begin
                if (out_ready && !fin) begin
                    load        = 1'b1;
                    crc_nxt     = crc_calc;
                    cnt_nxt     = byte_cnt + 7'd8;
                    tdata_nxt   = '0;
                    tkeep_nxt   = 8'hFF;
                    tlast_nxt   = 1'b0;
                    tuser_o_nxt = 1'b0;
                end
            end
            ST_FCS: begin
                if (out_ready) begin
                    load        = 1'b1;
                    tdata_nxt   = {32'h0, fcs_rem};
                    tkeep_nxt   = rem_keep;
                    tlast_nxt   = 1'b1;
                    tuser_o_nxt = tuser_acc;
                    tuser_nxt   = 1'b0;
                    state_nxt   = ST_PASS;
                end
            end
            default: state_nxt = ST_PASS;
        endcase
        if (fin) begin
            load      = 1'b1;
            crc_nxt   = CRC32_INIT;
            cnt_nxt   = '0;
            tdata_nxt = fin_data | ({32'h0, fcs} << {fin_m, 3'b000});
            if (fin_m <= 4'd4) begin
                tkeep_nxt   = count_keep(fin_m + 4'd4);
                tlast_nxt   = 1'b1;
                tuser_o_nxt = frame_user;
                tuser_nxt   = 1'b0;
                state_nxt   = ST_PASS;
            end else begin
                // FCS straddles the beat: the high FCS bytes go out next cycle.
                tkeep_nxt    = 8'hFF;
                tlast_nxt    = 1'b0;
                tuser_o_nxt  = 1'b0;
                tuser_nxt    = frame_user;
                fcs_rem_nxt  = fcs >> {(4'd8 - fin_m), 3'b000};
                rem_keep_nxt = count_keep(fin_m - 4'd4);
                state_nxt    = ST_FCS;
            end
        end
    end

    // Control state: FSM, running CRC, byte count, abort flag, pending FCS.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= ST_PASS;
            crc       <= CRC32_INIT;
            byte_cnt  <= '0;
            tuser_acc <= 1'b0;
            fcs_rem   <= '0;
            rem_keep  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            crc       <= crc_nxt;
            byte_cnt  <= cnt_nxt;
            tuser_acc <= tuser_nxt;
            fcs_rem   <= fcs_rem_nxt;
            rem_keep  <= rem_keep_nxt;
            ready_q   <= 1'b1;
        end
    end

    // Output register: load a new beat, or retire the current one on handshake.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= tdata_nxt;
            m_axis_tkeep  <= tkeep_nxt;
            m_axis_tlast  <= tlast_nxt;
            m_axis_tuser  <= tuser_o_nxt;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Count frames completed on the output port.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) frame_count <= '0;
        else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) frame_count <= frame_count + 32'd1;
    end

endmodule

// File: doc/eth_fcs_pad_insert.md
# eth_fcs_pad_insert

Ethernet TX framing stage between the UDP packet generator and the 10G MAC TX AXI4-Stream port. It accepts 64-bit AXI4-Stream frames without FCS and zero-pads runts to the 60-byte minimum. It computes CRC-32 over the frame and appends the 4-byte FCS, so the MAC receives wire-complete frames. Throughput is one beat per cycle, plus bubbles for pad beats and for any FCS overflow beat.

## Interface
- DATA_WIDTH, 64: tdata width; only 64 is supported.
- KEEP_WIDTH, 8: tkeep width, DATA_WIDTH/8.
- MIN_FRAME_BYTES, 60: pad target, excluding FCS.
- PAD_ENABLE, 1: 0 disables padding; FCS is always appended.
- aclk  in  1  single clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  64  frame data; byte 0 on wire = tdata[7:0].
- s_axis_tkeep  in  8  contiguous from bit 0; partial only on tlast beat.
- s_axis_tvalid / s_axis_tready  in / out  1  upstream handshake.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  1  abort mark; sticky per frame.
- m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser  out  64/8/1/1/1  frame to MAC.
- m_axis_tready  in  1  MAC backpressure.
- frame_count  out  32  frames emitted (tlast handshakes); wraps.

## Operation
- States: PASS, PAD, FCS.
- PASS: input beats are forwarded through one output register. CRC-32 updates on each accepted beat over the tkeep-valid bytes only.
- CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, FCS = ~crc. FCS is emitted LSB byte first, immediately after the last data byte.
- On a non-last input beat with tkeep≠0xFF, the beat is treated as 0xFF (bytes counted and CRC'd).
- Byte counter: 7 bits, saturating at 64, cleared at frame start.
- On the tlast beat, let total = byte count including that beat.
  - If PAD_ENABLE and total<60: zero-fill the rest of the beat and enter PAD. PAD emits zero bytes (included in CRC) until 60 bytes, then appends FCS.
  - Else, with n = bytes in the final data beat: n≤4 places the FCS in the same beat (tkeep widens to n+4 bits) and that beat carries tlast. n>4 places FCS bytes in the upper lanes and the remainder (n−4 bytes) in an extra FCS-state beat carrying tlast.
- A padded frame is always exactly 8 output beats, the last with tkeep 0xFF.
- s_axis_tready = (state==PASS) && (!m_axis_tvalid || m_axis_tready). It is 0 in PAD/FCS.
- m_axis_tuser = OR of all input tuser in the frame, asserted only on the output tlast beat. The FCS is still appended.
- frame_count increments on each m_axis tvalid&tready&tlast.

## Timing
- Reset values: m_axis_tvalid=0, tlast=0, tuser=0, tdata=0, tkeep=0, frame_count=0, state=PASS, CRC=0xFFFFFFFF, byte count=0. s_axis_tready=1 one cycle after areset deasserts.
- Reset mid-frame: the partial frame is dropped and m_axis_tvalid falls asynchronously. No tlast is emitted for the dropped frame.
- Latency: an input beat accepted in cycle t is on m_axis in cycle t+1.
- m_axis holds tdata/tkeep/tlast/tuser stable while tvalid && !tready. tvalid never drops without a handshake except on reset.
- Back-to-back frames: a new frame's first beat is accepted in the cycle after the previous tlast beat is loaded into the output register, or in the cycle after the FCS/PAD beat is loaded.
- Stall cost per frame: 0 cycles if last beat n≤4; 1 cycle if n>4; pad beats = 8 − input beats.

## Structure
- Package eth_fcs_pkg: CRC32_POLY_REFL, CRC32_INIT, CRC32_RESIDUE (0xDEBB20E3), MIN_FRAME_BYTES default, state enum.
- Sub-module eth_crc32_d64: combinational next-CRC from current CRC, 64-bit data and byte count 1..8.

## Test plan
- 48-byte frame (6 full beats): 8 output beats, bytes 48–59 = 0, last tkeep 0xFF. Receiver CRC over all 64 bytes, no final xor, = 0xDEBB20E3.
- 61-byte frame, last tkeep 0x1F: 9 beats; beat 8 tkeep 0xFF (5 data + 3 FCS bytes), beat 9 tkeep 0x01 with tlast; residue 0xDEBB20E3; s_axis_tready low for 1 cycle.
- 68-byte frame, last tkeep 0x0F: 9 output beats, last tkeep 0xFF with tlast, no stall.
- Back-to-back 64-byte frames at full rate, random 50% m_axis_tready: every frame 9 beats, last tkeep 0x0F, data stable while stalled, frame_count matches.
- tuser=1 on beat 2 of a 48-byte frame: output frame 8 beats, tuser=1 only on the tlast beat.
- areset pulsed at beat 3 of a 64-byte frame: m_axis_tvalid=0 immediately. The next frame is output intact with correct FCS, and frame_count counts only the completed frame.
